// File: rtl/led_chase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_chase_ctrl
//  Purpose  : Command-driven 8-LED chaser. Owns the step prescaler and pattern
//             register; four display modes at eight speeds.
//  Revision : 1.0  initial release
// ============================================================================
module led_chase_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 20000000,
    parameter int CNT_W    = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_speed,
    output logic [WIDTH-1:0] op,
    output logic             busy,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_START = 2'b00;
    localparam logic [1:0] c_OP_STOP  = 2'b01;
    localparam logic [1:0] c_OP_PAUSE = 2'b10;
    localparam logic [1:0] c_OP_LOAD  = 2'b11;

    localparam logic [1:0] c_MODE_CHASE_R = 2'd0;
    localparam logic [1:0] c_MODE_CHASE_L = 2'd1;
    localparam logic [1:0] c_MODE_BOUNCE  = 2'd2;
    localparam logic [1:0] c_MODE_BLINK   = 2'd3;

    localparam logic [CNT_W-1:0] c_TICK_DIV = CNT_W'(TICK_DIV);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   pattern_q, pattern_d;
    logic [WIDTH-1:0]   op_q,      op_d;
    logic [1:0]         mode_q,    mode_d;
    logic [2:0]         speed_q,   speed_d;
    logic [CNT_W-1:0]   presc_q,   presc_d;
    logic               dir_q,     dir_d;     // 0 = heading right, 1 = heading left
    logic               ready_q,   ready_d;
    logic               wrap_q,    wrap_d;

    logic [CNT_W-1:0]   w_limit_raw;
    logic [CNT_W-1:0]   w_limit_m1;
    logic               w_tick;
    logic               w_accept;
    logic [WIDTH-1:0]   w_adv_pat;
    logic               w_adv_dir;

    function automatic logic [WIDTH-1:0] f_start(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        case (m)
            c_MODE_CHASE_L: v = {{(WIDTH-1){1'b0}}, 1'b1};
            c_MODE_BLINK:   v = {WIDTH{1'b1}};
            default:        v = {1'b1, {(WIDTH-1){1'b0}}};
        endcase
        return v;
    endfunction

    // A fast speed can shift the divider to zero; clamp so the step is every cycle.
    assign w_limit_raw = c_TICK_DIV >> speed_q;
    assign w_limit_m1  = (w_limit_raw == '0) ? '0 : (w_limit_raw - CNT_W'(1));
    assign w_tick      = (state_q == ST_RUN) && (presc_q == w_limit_m1);
    assign w_accept    = cmd_valid && ready_q;

    always_comb begin
        w_adv_pat = pattern_q;
        w_adv_dir = dir_q;
        case (mode_q)
            c_MODE_CHASE_R: w_adv_pat = {pattern_q[0], pattern_q[WIDTH-1:1]};
            c_MODE_CHASE_L: w_adv_pat = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            c_MODE_BOUNCE: begin
                // Turn around on the step that lands on an endpoint so it shows once.
                if (!dir_q) begin
                    w_adv_pat = pattern_q >> 1;
                    w_adv_dir = pattern_q[1];
                end else begin
                    w_adv_pat = pattern_q << 1;
                    w_adv_dir = ~pattern_q[WIDTH-2];
                end
            end
            c_MODE_BLINK:   w_adv_pat = ~pattern_q;
            default:        w_adv_pat = pattern_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        speed_d   = speed_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        ready_d   = 1'b1;
        wrap_d    = 1'b0;

        if (w_accept) begin
            ready_d = 1'b0;
            case (cmd_op)
                c_OP_START: begin
                    state_d   = ST_RUN;
                    pattern_d = f_start(mode_q);
                    presc_d   = '0;
                    dir_d     = 1'b0;
                end
                c_OP_STOP: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
                c_OP_PAUSE: begin
                    case (state_q)
                        ST_RUN:    state_d = ST_PAUSED;
                        ST_PAUSED: state_d = ST_RUN;
                        default:   state_d = state_q;
                    endcase
                end
                c_OP_LOAD: begin
                    mode_d    = cmd_mode;
                    speed_d   = cmd_speed;
                    pattern_d = f_start(cmd_mode);
                    presc_d   = '0;
                    dir_d     = 1'b0;
                end
                default: state_d = state_q;
            endcase
        end else if (state_q == ST_RUN) begin
            if (w_tick) begin
                presc_d   = '0;
                pattern_d = w_adv_pat;
                dir_d     = w_adv_dir;
                wrap_d    = (w_adv_pat == f_start(mode_q));
            end else begin
                presc_d = presc_q + CNT_W'(1);
            end
        end

        op_d = (state_d == ST_IDLE) ? '0 : pattern_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            op_q      <= '0;
            mode_q    <= '0;
            speed_q   <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            ready_q   <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            op_q      <= op_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            ready_q   <= ready_d;
            wrap_q    <= wrap_d;
        end
    end

    assign op         = op_q;
    assign busy       = (state_q != ST_IDLE);
    assign cmd_ready  = ready_q;
    assign wrap_pulse = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_led_chase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_chase_ctrl
//  Purpose  : Directed scoreboard bench for led_chase_ctrl (TICK_DIV = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_chase_ctrl;

    localparam int c_WIDTH    = 8;
    localparam int c_TICK_DIV = 16;
    localparam int c_CNT_W    = 35;

    localparam logic [1:0] c_START = 2'b00;
    localparam logic [1:0] c_STOP  = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_LOAD  = 2'b11;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [1:0]         cmd_mode;
    logic [2:0]         cmd_speed;
    logic [c_WIDTH-1:0] op;
    logic               busy;
    logic               wrap_pulse;

    always #5 clk = ~clk;

    led_chase_ctrl #(
        .WIDTH    (c_WIDTH),
        .TICK_DIV (c_TICK_DIV),
        .CNT_W    (c_CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mode   (cmd_mode),
        .cmd_speed  (cmd_speed),
        .op         (op),
        .busy       (busy),
        .wrap_pulse (wrap_pulse)
    );

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] op;
        logic       busy;
        logic       wrap;
        logic       rdy;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic       hold_valid = 1'b0;
    logic [7:0] cur_tag = 8'd0;

    logic [7:0] c_chase_r [0:7]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] c_bounce  [0:13] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                     8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Monitor: every cycle with a pending expectation is one output vector.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({op, busy, wrap_pulse, cmd_ready} !== {mon_e.op, mon_e.busy, mon_e.wrap, mon_e.rdy}) begin
                n_err++;
                $display("FAIL test%0d vec%0d: got op=%h busy=%b wrap=%b rdy=%b, want op=%h busy=%b wrap=%b rdy=%b",
                         mon_e.tag, n_vec, op, busy, wrap_pulse, cmd_ready,
                         mon_e.op, mon_e.busy, mon_e.wrap, mon_e.rdy);
            end
        end
    end

    task automatic cyc(input logic [7:0] e_op, input logic e_busy, input logic e_wrap, input logic e_rdy);
        exp_t e;
        @(posedge clk);
        #2;
        if (!hold_valid) cmd_valid = 1'b0;
        e.tag  = cur_tag;
        e.op   = e_op;
        e.busy = e_busy;
        e.wrap = e_wrap;
        e.rdy  = e_rdy;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [7:0] v, input int n, input logic wrap_first);
        for (int i = 0; i < n; i++) cyc(v, 1'b1, wrap_first && (i == 0), 1'b1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] m, input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_mode  = m;
        cmd_speed = s;
    endtask

    task automatic idle_cmd(input logic [1:0] o, input logic [1:0] m, input logic [2:0] s);
        issue(o, m, s);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = c_START;
        cmd_mode  = 2'd0;
        cmd_speed = 3'd0;
        #1;

        // Reset held while a START is presented
        cur_tag    = 8'd1;
        rst_n      = 1'b0;
        hold_valid = 1'b1;
        issue(c_START, 2'd0, 3'd0);
        repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b1);
        rst_n      = 1'b1;
        hold_valid = 1'b0;
        cmd_valid  = 1'b0;
        repeat (50) cyc(8'h00, 1'b0, 1'b0, 1'b1);

        // CHASE_R at speed 0 (limit 16), then STOP on a tick cycle
        cur_tag = 8'd2;
        idle_cmd(c_LOAD, 2'd0, 3'd0);
        issue(c_START, 2'd0, 3'd0);
        cyc(8'h80, 1'b1, 1'b0, 1'b0);
        hold(8'h80, 15, 1'b0);
        for (int s = 0; s < 8; s++) hold(c_chase_r[s], 16, s == 7);
        idle_cmd(c_STOP, 2'd0, 3'd0);

        // BOUNCE at speed 2 (limit 4), one full period plus one step
        cur_tag = 8'd3;
        idle_cmd(c_LOAD, 2'd2, 3'd2);
        issue(c_START, 2'd0, 3'd0);
        cyc(8'h80, 1'b1, 1'b0, 1'b0);
        hold(8'h80, 3, 1'b0);
        for (int s = 0; s < 14; s++) hold(c_bounce[s], 4, s == 13);
        hold(8'h40, 4, 1'b0);
        idle_cmd(c_STOP, 2'd0, 3'd0);

        // CHASE_L pause 5 cycles into a period, then pause on a tick cycle
        cur_tag = 8'd4;
        idle_cmd(c_LOAD, 2'd1, 3'd0);
        issue(c_START, 2'd0, 3'd0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        hold(8'h01, 5, 1'b0);
        issue(c_PAUSE, 2'd0, 3'd0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        hold(8'h01, 100, 1'b0);
        issue(c_PAUSE, 2'd0, 3'd0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        hold(8'h01, 10, 1'b0);
        hold(8'h02, 16, 1'b0);
        issue(c_PAUSE, 2'd0, 3'd0);
        cyc(8'h02, 1'b1, 1'b0, 1'b0);
        hold(8'h02, 5, 1'b0);
        issue(c_PAUSE, 2'd0, 3'd0);
        cyc(8'h02, 1'b1, 1'b0, 1'b0);
        hold(8'h04, 16, 1'b0);
        cyc(8'h08, 1'b1, 1'b0, 1'b1);

        // BLINK at speed 7 (limit clamps to 1) loaded mid-run, then STOP
        cur_tag = 8'd5;
        issue(c_LOAD, 2'd3, 3'd7);
        cyc(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(i[0] ? 8'hFF : 8'h00, 1'b1, i[0], 1'b1);
        idle_cmd(c_STOP, 2'd0, 3'd0);

        // Back-to-back START with valid held high, then async reset mid-BOUNCE
        cur_tag = 8'd6;
        idle_cmd(c_LOAD, 2'd2, 3'd2);
        hold_valid = 1'b1;
        issue(c_START, 2'd0, 3'd0);
        for (int i = 0; i < 6; i++) cyc(8'h80, 1'b1, 1'b0, i[0]);
        hold_valid = 1'b0;
        cmd_valid  = 1'b0;
        hold(8'h80, 2, 1'b0);
        hold(8'h40, 4, 1'b0);
        cyc(8'h20, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b1);
        // Mode and speed were reset too: CHASE_R at limit 16
        issue(c_START, 2'd0, 3'd0);
        cyc(8'h80, 1'b1, 1'b0, 1'b0);
        hold(8'h80, 15, 1'b0);
        cyc(8'h40, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_chase_ctrl.md
Name: led_chase_ctrl

Overview:
- Command-driven controller for the board's 8-LED chaser output.
- Owns the tick prescaler and the pattern register.
- Sequences four display modes at eight selectable speeds.
- Host logic (buttons/debouncer FSM) starts, stops, pauses and reconfigures the display through a valid/ready command port.

Parameters:
WIDTH, 8, LED count and pattern width
TICK_DIV, 20000000, clk cycles per pattern step at speed 0
CNT_W, 35, prescaler counter width; must hold TICK_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 START, 01 STOP, 10 PAUSE toggle, 11 LOAD
cmd_mode  input  2  LOAD only: 0 CHASE_R, 1 CHASE_L, 2 BOUNCE, 3 BLINK
cmd_speed  input  3  LOAD only: step period = TICK_DIV >> cmd_speed
op  output  WIDTH  registered LED pattern
busy  output  1  state is RUN or PAUSED
wrap_pulse  output  1  one-cycle pulse when the pattern returns to the mode start value

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, op=0, mode=0, speed=0, prescaler=0, bounce direction=right, cmd_ready=1, busy=0, wrap_pulse=0.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready is registered. It drops to 0 for exactly the cycle after an acceptance, then returns to 1.
  - Commands are never dropped. Effects are visible one cycle after acceptance.
- States: IDLE, RUN, PAUSED. op=0 in IDLE. op=pattern in RUN and PAUSED.
- START:
  - From any state, go to RUN.
  - pattern = mode start value, prescaler=0, bounce direction=right.
- STOP: from any state, go to IDLE. op=0. Prescaler cleared.
- PAUSE toggle:
  - RUN → PAUSED: prescaler and pattern hold.
  - PAUSED → RUN: resumes counting from the held prescaler value.
  - In IDLE: accepted, no effect.
- LOAD:
  - Latches mode and speed in any state. State is unchanged.
  - pattern = new mode's start value, prescaler=0.
- Step period: limit = TICK_DIV >> speed; if the result is 0, use 1.
- Prescaler:
  - In RUN it increments every cycle.
  - When it equals limit-1, it is cleared and the pattern advances. The new op is visible the next cycle.
  - The first advance therefore occurs limit cycles after the start value appears.
- Patterns (WIDTH=8 shown):
  - CHASE_R: start 0x80, shift right, 0x01 → 0x80.
  - CHASE_L: start 0x01, shift left, 0x80 → 0x01.
  - BOUNCE: start 0x80, shift right down to 0x01, then left back up to 0x80. Each endpoint is shown once. Period is 2*WIDTH-2 = 14 steps.
  - BLINK: start 0xFF, alternates 0xFF/0x00.
- wrap_pulse: asserted in the same cycle op takes the start value via an advance. Not asserted on START or LOAD.
- Simultaneous command and tick: the command wins and the advance is suppressed.
  - STOP/START/LOAD clear the prescaler.
  - PAUSE leaves the prescaler at limit-1, so the step fires on the first RUN cycle after resume.
- Speed change by LOAD mid-run takes effect immediately. The prescaler is cleared, so the compare never passes the new limit.
- Asynchronous reset mid-operation: all registers return to reset values immediately. No pulse outputs are asserted.

Test Plan:
- Reset: rst_n low with cmd_valid=1, cmd_op=START → op=0x00, busy=0, cmd_ready=1, wrap_pulse=0. Deassert and idle 50 cycles → op stays 0.
- TICK_DIV=16, LOAD mode0 speed0, then START → op=0x80. Steps every 16 cycles: 0x40, 0x20 … 0x01, then 0x80. wrap_pulse high exactly on the 0x80 cycle. cmd_ready low 1 cycle after each accept.
- TICK_DIV=16, LOAD mode2 speed2 (limit 4), START → 14-step sequence 80,40,20,10,08,04,02,01,02,04,08,10,20,40, then 80 with wrap_pulse, changing every 4 cycles.
- Pause: CHASE_L running, PAUSE issued 5 cycles into a period → op frozen for 100 cycles. PAUSE again → next step after 11 more cycles. Check PAUSE collision on a tick cycle: op holds, then advances on the first resumed cycle.
- LOAD mode3 speed7 with TICK_DIV=16 (limit 1) while RUN → op=0xFF, then toggles 0x00/0xFF every cycle, wrap_pulse on each 0xFF. STOP → op=0, busy=0 next cycle.
- Back-to-back cmd_valid held high → accepts every other cycle only. Async rst_n pulse mid-BOUNCE → immediate op=0, IDLE; START afterwards begins at 0x80 heading right.
